// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch board front end.
//   CLK_FREQ_HZ             system clock frequency
//   DEBOUNCE_CYCLES_DEF     default debounce window (10 ms)
//   REFRESH_CYCLES_DEF      default per-digit display time (1 ms)
//   BTN_START/STOP/RESET    bit positions inside the button vectors
//   seg_glyph()             BCD digit to active-low {g..a} segment pattern
package stopwatch_pkg;

    localparam int CLK_FREQ_HZ        = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 100;
    localparam int REFRESH_CYCLES_DEF  = CLK_FREQ_HZ / 1000;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_RESET = 2;

    // Codes 10..15 are not decimal digits and render blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_display_io_if.sv
// Board-side signal bundle of the stopwatch front end.
//   btn      raw buttons {reset, stop, start}, active-high
//   btn_db   debounced button levels, same bit order
//   encoded  packed BCD digits, digit 0 in the low nibble
//   anode    active-low digit enables
//   cathode  active-low segments {g..a}
//   dp       active-low decimal point
// slave: the front end itself; master: whoever drives buttons/digits.
interface stopwatch_display_io_if #(
    parameter int NUM_SEGMENTS = 4,
    parameter int BITS         = 16
);
    logic [2:0]              btn;
    logic [2:0]              btn_db;
    logic [BITS-1:0]         encoded;
    logic [NUM_SEGMENTS-1:0] anode;
    logic [6:0]              cathode;
    logic                    dp;

    modport master (
        output btn, encoded,
        input  btn_db, anode, cathode, dp
    );

    modport slave (
        input  btn, encoded,
        output btn_db, anode, cathode, dp
    );
endinterface

// File: rtl/stopwatch_display_io_debounce_cell.sv
// Single-button debouncer: 2-flop synchronizer followed by a stability
// counter. The output follows the input only after it has differed from the
// current output for DEBOUNCE_CYCLES consecutive cycles.
//   clk        system clock
//   rst        asynchronous active-low reset
//   bouncy     raw asynchronous button
//   debounced  clean level
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic bouncy,
    output logic debounced
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= bouncy;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign debounced = db_q;

endmodule

// File: rtl/stopwatch_display_io.sv
// Stopwatch board front end: debounces the three buttons and scans a
// multiplexed active-low seven-segment display from a packed BCD word.
//   clk  system clock
//   rst  asynchronous active-low reset
//   io   stopwatch_display_io_if.slave (btn, btn_db, encoded, anode,
//        cathode, dp); BITS must equal 4*NUM_SEGMENTS
module stopwatch_display_io
    import stopwatch_pkg::*;
#(
    parameter int NUM_SEGMENTS    = 4,
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REFRESH_CYCLES  = REFRESH_CYCLES_DEF,
    parameter int DP_DIGIT        = 2
) (
    input logic clk,
    input logic rst,
    stopwatch_display_io_if.slave io
);
    localparam int RW = $clog2(REFRESH_CYCLES > 1 ? REFRESH_CYCLES : 2);
    localparam int IW = $clog2(NUM_SEGMENTS > 1 ? NUM_SEGMENTS : 2);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_SEGMENTS - 1);
    localparam logic [IW-1:0] IDX_DP   = IW'(DP_DIGIT);

    // ---------------- buttons ----------------
    logic db_start, db_stop, db_reset;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk       (clk),
        .rst       (rst),
        .bouncy    (io.btn[BTN_START]),
        .debounced (db_start)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk       (clk),
        .rst       (rst),
        .bouncy    (io.btn[BTN_STOP]),
        .debounced (db_stop)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk       (clk),
        .rst       (rst),
        .bouncy    (io.btn[BTN_RESET]),
        .debounced (db_reset)
    );

    assign io.btn_db = {db_reset, db_stop, db_start};

    // ---------------- display scan ----------------
    logic [RW-1:0]           ref_q, ref_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_SEGMENTS-1:0] anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic                    dp_q, dp_d;
    logic [3:0]              digit;

    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Outputs are decoded from the current index and the live digit word, so
    // anode and glyph always move together on the same edge.
    always_comb begin
        digit   = 4'hF;
        anode_d = '1;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (idx_q == IW'(i)) begin
                anode_d[i] = 1'b0;
                if (4 * i + 3 < BITS) begin
                    digit = io.encoded[4 * i +: 4];
                end
            end
        end
        cathode_d = seg_glyph(digit);
        dp_d      = (idx_q == IDX_DP) ? 1'b0 : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q     <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_q      <= dp_d;
        end
    end

    assign io.anode   = anode_q;
    assign io.cathode = cathode_q;
    assign io.dp      = dp_q;

endmodule

// File: tb/tb_stopwatch_display_io.sv
module tb_stopwatch_display_io;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    stopwatch_display_io_if #(.NUM_SEGMENTS(4), .BITS(16)) io ();

    stopwatch_display_io #(
        .NUM_SEGMENTS    (4),
        .BITS            (16),
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (3),
        .DP_DIGIT        (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_anode"},   32'(io.anode),   32'hF);
        chk({tag, "_cathode"}, 32'(io.cathode), 32'h7F);
        chk({tag, "_dp"},      32'(io.dp),      32'h1);
        chk({tag, "_btn_db"},  32'(io.btn_db),  32'h0);
    endtask

    typedef struct {
        logic [15:0] enc;
        logic [3:0]  an;
        logic [6:0]  cat;
        logic        dp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // digit frames in scan order, 3 cycles each
        tbl[0] = '{16'h1234, 4'b1110, 7'b0011001, 1'b1};
        tbl[1] = '{16'h1234, 4'b1101, 7'b0110000, 1'b1};
        tbl[2] = '{16'h1234, 4'b1011, 7'b0100100, 1'b0};
        tbl[3] = '{16'h1234, 4'b0111, 7'b1111001, 1'b1};
        tbl[4] = '{16'h00A0, 4'b1110, 7'b1000000, 1'b1};
        tbl[5] = '{16'h00A0, 4'b1101, 7'b1111111, 1'b1};
        tbl[6] = '{16'h00A0, 4'b1011, 7'b1000000, 1'b0};
        tbl[7] = '{16'h00A0, 4'b0111, 7'b1000000, 1'b1};

        // ---- reset with arbitrary inputs ----
        rst        = 1'b0;
        io.btn     = 3'b111;
        io.encoded = 16'h5A5A;
        repeat (3) step();
        chk_reset_outputs("rst_hold");

        io.btn     = 3'b000;
        io.encoded = tbl[0].enc;
        step();
        rst = 1'b1;

        // ---- scan + blank, table driven ----
        for (int i = 0; i < 8; i++) begin
            io.encoded = tbl[i].enc;
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("scan%0d_%0d_anode", i, k),   32'(io.anode),   32'(tbl[i].an));
                chk($sformatf("scan%0d_%0d_cathode", i, k), 32'(io.cathode), 32'(tbl[i].cat));
                chk($sformatf("scan%0d_%0d_dp", i, k),      32'(io.dp),      32'(tbl[i].dp));
            end
        end
        chk("scan_btn_db_idle", 32'(io.btn_db), 32'h0);

        // ---- debounce press on start ----
        io.btn[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("press_db0_c%0d", k), 32'(io.btn_db[0]), (k >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("press_db21_c%0d", k), 32'(io.btn_db[2:1]), 32'h0);
        end

        // ---- glitch rejection on stop ----
        io.btn[1] = 1'b1;
        repeat (3) begin
            step();
            chk("glitch_hi_db1", 32'(io.btn_db[1]), 32'h0);
        end
        io.btn[1] = 1'b0;
        step();
        chk("glitch_lo_db1", 32'(io.btn_db[1]), 32'h0);
        io.btn[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("glitch_db1_c%0d", k), 32'(io.btn_db[1]), (k >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("hold_db0_c%0d", k), 32'(io.btn_db[0]), 32'h1);
        end

        // ---- release stop so btn_db = 001 ----
        io.btn[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("release_db1_c%0d", k), 32'(io.btn_db[1]), (k >= 6) ? 32'h0 : 32'h1);
        end
        chk("pre_rst_btn_db", 32'(io.btn_db), 32'h1);

        // ---- mid-operation reset while digit 2 is lit ----
        begin
            int n;
            n = 0;
            while (io.anode !== 4'b1011 && n < 20) begin
                step();
                n++;
            end
            chk("find_digit2_in_budget", 32'(n < 20), 32'h1);
        end
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        step();
        chk_reset_outputs("rst_mid_held");
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rearm_db0_c%0d", k), 32'(io.btn_db[0]), (k >= 6) ? 32'h1 : 32'h0);
            if (k == 1) chk("rearm_anode_c1", 32'(io.anode), 32'hE);
            if (k == 3) chk("rearm_anode_c3", 32'(io.anode), 32'hE);
            if (k == 4) chk("rearm_anode_c4", 32'(io.anode), 32'hD);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
